// File: rtl/switches_pkg.sv
// Shared constants for the switch/button reader: selector codes and result width.
package switches_pkg;

  localparam int unsigned RESULT_W = 16;

  localparam logic [1:0] SEL_SW  = 2'd0;
  localparam logic [1:0] SEL_BTN = 2'd1;
  localparam logic [1:0] SEL_EVT = 2'd2;
  localparam logic [1:0] SEL_RAW = 2'd3;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer, sample prescaler and per-bit history debouncer for a bus of pad inputs.
module input_debouncer #(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned SAMPLE_DIV     = 100000,
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] deb_o,
  output logic [WIDTH-1:0] rise_o
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STABLE_SAMPLES-1:0] hist_q [WIDTH];
  logic [STABLE_SAMPLES-1:0] hist_d [WIDTH];
  logic tick;

  always_comb begin
    sync1_d = pad_i;
    sync2_d = sync1_q;
    tick    = (cnt_q == CNT_MAX);
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    deb_d   = deb_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      hist_d[i] = hist_q[i];
      if (tick) begin
        // Newest sample enters at bit 0; a uniform history decides the level.
        hist_d[i] = {hist_q[i][STABLE_SAMPLES-2:0], sync2_q[i]};
        if (&hist_d[i]) begin
          deb_d[i] = 1'b1;
        end else if (~|hist_d[i]) begin
          deb_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  assign sync_o = sync2_q;
  assign deb_o  = deb_q;
  assign rise_o = deb_d & ~deb_q;

endmodule

// File: rtl/switches_ctrl.sv
// Slide-switch / push-button reader with a start/done call interface and sticky press events.
// Optional SWITCHES_CTRL_IRQ_EN adds an irq output that is the registered OR of the event bits.
module switches_ctrl
  import switches_pkg::*;
#(
  parameter int unsigned N_SW           = 16,
  parameter int unsigned N_BTN          = 5,
  parameter int unsigned SAMPLE_DIV     = 100000,
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_port,
  input  logic [1:0]          sel,
  input  logic [N_SW-1:0]     sw_pad,
  input  logic [N_BTN-1:0]    btn_pad,
  output logic                done_port,
  output logic [RESULT_W-1:0] return_port
`ifdef SWITCHES_CTRL_IRQ_EN
  ,
  output logic                irq
`endif
);

  logic [N_SW-1:0]  sw_sync, sw_deb, sw_rise;
  logic [N_BTN-1:0] btn_sync, btn_deb, btn_rise;
  logic [N_BTN-1:0] evt_q, evt_d;
  logic             done_q, done_d;
  logic [RESULT_W-1:0] ret_q, ret_d;
  logic [RESULT_W-1:0] sw_deb_ext, sw_sync_ext, btn_deb_ext, evt_ext;

  input_debouncer #(
    .WIDTH          (N_SW),
    .SAMPLE_DIV     (SAMPLE_DIV),
    .STABLE_SAMPLES (STABLE_SAMPLES)
  ) u_sw_deb (
    .clock  (clock),
    .reset  (reset),
    .pad_i  (sw_pad),
    .sync_o (sw_sync),
    .deb_o  (sw_deb),
    .rise_o (sw_rise)
  );

  input_debouncer #(
    .WIDTH          (N_BTN),
    .SAMPLE_DIV     (SAMPLE_DIV),
    .STABLE_SAMPLES (STABLE_SAMPLES)
  ) u_btn_deb (
    .clock  (clock),
    .reset  (reset),
    .pad_i  (btn_pad),
    .sync_o (btn_sync),
    .deb_o  (btn_deb),
    .rise_o (btn_rise)
  );

  // Wide switch banks are truncated to the result width; narrow buses are zero-extended.
  if (N_SW >= RESULT_W) begin : g_sw_trunc
    assign sw_deb_ext  = sw_deb[RESULT_W-1:0];
    assign sw_sync_ext = sw_sync[RESULT_W-1:0];
  end else begin : g_sw_ext
    assign sw_deb_ext  = {{(RESULT_W - N_SW){1'b0}}, sw_deb};
    assign sw_sync_ext = {{(RESULT_W - N_SW){1'b0}}, sw_sync};
  end

  if (N_BTN >= RESULT_W) begin : g_btn_trunc
    assign btn_deb_ext = btn_deb[RESULT_W-1:0];
    assign evt_ext     = evt_q[RESULT_W-1:0];
  end else begin : g_btn_ext
    assign btn_deb_ext = {{(RESULT_W - N_BTN){1'b0}}, btn_deb};
    assign evt_ext     = {{(RESULT_W - N_BTN){1'b0}}, evt_q};
  end

  always_comb begin
    done_d = start_port;
    ret_d  = ret_q;
    evt_d  = evt_q | btn_rise;
    if (start_port) begin
      unique case (sel)
        SEL_SW:  ret_d = sw_deb_ext;
        SEL_BTN: ret_d = btn_deb_ext;
        SEL_EVT: begin
          ret_d = evt_ext;
          // A press landing on the clearing edge survives the clear.
          evt_d = btn_rise;
        end
        SEL_RAW: ret_d = sw_sync_ext;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      evt_q  <= '0;
      done_q <= 1'b0;
      ret_q  <= '0;
    end else begin
      evt_q  <= evt_d;
      done_q <= done_d;
      ret_q  <= ret_d;
    end
  end

  assign done_port   = done_q;
  assign return_port = ret_q;

`ifdef SWITCHES_CTRL_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = |evt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule
